// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for the five-stage pipeline.
// Define HAZARD_FORWARD_EN to enable EX-stage forwarding; otherwise RAW hazards stall in ID.
module hazard_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemAccessM,
  input  logic             MemReadyM,
  input  logic             PCSrcM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCnt,
  output logic             MemErr
);

  localparam int unsigned WAIT_W  = 8;
  localparam int unsigned WAIT_EW = WAIT_W + 1;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [WAIT_EW-1:0] wait_inc;
  logic              mem_err_set;
  logic              load_use, data_stall, mem_wait_req, timeout;

  assign load_use = RegWriteE & MemtoRegE & (WriteRegE != 5'd0) &
                    ((WriteRegE == RsD) | (WriteRegE == RtD));

`ifdef HAZARD_FORWARD_EN
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       wr_m,
                                         input logic [4:0] dst_m,
                                         input logic       wr_w,
                                         input logic [4:0] dst_w);
    if (wr_m && (dst_m != 5'd0) && (dst_m == src))      return 2'b10;
    else if (wr_w && (dst_w != 5'd0) && (dst_w == src)) return 2'b01;
    else                                                return 2'b00;
  endfunction

  assign data_stall = load_use;
  assign ForwardAE  = fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW) & {2{RESET_N}};
  assign ForwardBE  = fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW) & {2{RESET_N}};
`else
  // Without bypassing, any in-flight E/M producer of an ID source must drain first.
  logic raw_e, raw_m, unused_fwd;
  assign raw_e = RegWriteE & (WriteRegE != 5'd0) & ((WriteRegE == RsD) | (WriteRegE == RtD));
  assign raw_m = RegWriteM & (WriteRegM != 5'd0) & ((WriteRegM == RsD) | (WriteRegM == RtD));
  assign data_stall = load_use | raw_e | raw_m;
  assign ForwardAE  = 2'b00;
  assign ForwardBE  = 2'b00;
  assign unused_fwd = ^{RsE, RtE, WriteRegW, RegWriteW};
`endif

  assign mem_wait_req = MemAccessM & ~MemReadyM;
  assign wait_inc     = {1'b0, wait_cnt} + WAIT_EW'(1);
  assign timeout      = (wait_inc >= WAIT_EW'(MEM_WAIT_MAX));

  // Next-state and stall/flush decode; everything forced low while in reset.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mem_err_set  = 1'b0;
    StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0;
    FlushD = 1'b0; FlushE = 1'b0; FlushM = 1'b0; FlushW = 1'b0;
    case (state)
      RUN: begin
        if (mem_wait_req) begin
          StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1; FlushW = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end else if (PCSrcM) begin
          FlushD = 1'b1; FlushE = 1'b1; FlushM = 1'b1;
        end else if (data_stall) begin
          StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
        end
      end
      MEM_WAIT: begin
        StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1; FlushW = 1'b1;
        wait_cnt_nxt = wait_inc[WAIT_W-1:0];
        if (MemReadyM) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (timeout) begin
          mem_err_set  = 1'b1;
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end
      end
      default: state_nxt = RUN;
    endcase
    if (!RESET_N) begin
      StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0;
      FlushD = 1'b0; FlushE = 1'b0; FlushM = 1'b0; FlushW = 1'b0;
    end
  end

  // State, wait counter, saturating stall counter and sticky timeout flag.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= RUN;
      wait_cnt <= '0;
      StallCnt <= '0;
      MemErr   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      MemErr   <= MemErr | mem_err_set;
      if (StallF && (StallCnt != {CNT_W{1'b1}}))
        StallCnt <= StallCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational vector table plus multi-cycle sequences.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 3;
`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic CLOCK = 1'b0;
  logic RESET_N;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemAccessM, MemReadyM, PCSrcM;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] StallCnt;
  logic MemErr;
  logic [7:0] so;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl #(.MEM_WAIT_MAX(4), .CNT_W(CNT_W)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemAccessM(MemAccessM), .MemReadyM(MemReadyM), .PCSrcM(PCSrcM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallCnt(StallCnt), .MemErr(MemErr)
  );

  always #5 CLOCK = ~CLOCK;

  assign so = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW};

  localparam logic [7:0] O_IDLE = 8'h00;
  localparam logic [7:0] O_LU   = 8'hC4;
  localparam logic [7:0] O_BR   = 8'h0E;
  localparam logic [7:0] O_MW   = 8'hF1;

  typedef struct {
    string      name;
    logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
    logic       rwe, m2re, rwm, rww, pcsrc;
    logic [7:0] exp_fw, exp_nf;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vt[14];

  function automatic vec_t mk(input string n,
                              input logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw,
                              input logic rwe, m2re, rwm, rww, pcsrc,
                              input logic [7:0] efw, enf, input logic [1:0] fa, fb);
    vec_t v;
    v.name = n; v.rsd = rsd; v.rtd = rtd; v.rse = rse; v.rte = rte;
    v.wre = wre; v.wrm = wrm; v.wrw = wrw;
    v.rwe = rwe; v.m2re = m2re; v.rwm = rwm; v.rww = rww; v.pcsrc = pcsrc;
    v.exp_fw = efw; v.exp_nf = enf; v.fa = fa; v.fb = fb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    MemAccessM = 1'b0; MemReadyM = 1'b0; PCSrcM = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    clear_inputs();
    RsD = v.rsd; RtD = v.rtd; RsE = v.rse; RtE = v.rte;
    WriteRegE = v.wre; WriteRegM = v.wrm; WriteRegW = v.wrw;
    RegWriteE = v.rwe; MemtoRegE = v.m2re; RegWriteM = v.rwm; RegWriteW = v.rww;
    PCSrcM = v.pcsrc;
  endtask

  task automatic do_reset();
    @(negedge CLOCK);
    RESET_N = 1'b0;
    clear_inputs();
    @(negedge CLOCK);
    RESET_N = 1'b1;
  endtask

  task automatic set_load_use();
    clear_inputs();
    RegWriteE = 1'b1; MemtoRegE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8;
  endtask

  initial begin
    //          name        rsd rtd rse rte wre wrm wrw  rwe m2r rwm rww pc  exp_fw  exp_nf  fa     fb
    vt[0]  = mk("idle",      0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, O_IDLE, O_IDLE, 2'b00, 2'b00);
    vt[1]  = mk("lu_rs",     8,  0,  0,  0,  8,  0,  0,  1,  1,  0,  0,  0, O_LU,   O_LU,   2'b00, 2'b00);
    vt[2]  = mk("lu_rt",     0,  8,  0,  0,  8,  0,  0,  1,  1,  0,  0,  0, O_LU,   O_LU,   2'b00, 2'b00);
    vt[3]  = mk("lu_r0",     0,  0,  0,  0,  0,  0,  0,  1,  1,  0,  0,  0, O_IDLE, O_IDLE, 2'b00, 2'b00);
    vt[4]  = mk("lu_nowr",   8,  0,  0,  0,  8,  0,  0,  0,  1,  0,  0,  0, O_IDLE, O_IDLE, 2'b00, 2'b00);
    vt[5]  = mk("br_lu",     8,  0,  0,  0,  8,  0,  0,  1,  1,  0,  0,  1, O_BR,   O_BR,   2'b00, 2'b00);
    vt[6]  = mk("fwd_m",     0,  0,  5,  0,  0,  5,  5,  0,  0,  1,  1,  0, O_IDLE, O_IDLE, 2'b10, 2'b00);
    vt[7]  = mk("fwd_w",     0,  0,  5,  0,  0,  0,  5,  0,  0,  1,  1,  0, O_IDLE, O_IDLE, 2'b01, 2'b00);
    vt[8]  = mk("fwd_r0",    0,  0,  0,  0,  0,  5,  5,  0,  0,  1,  1,  0, O_IDLE, O_IDLE, 2'b00, 2'b00);
    vt[9]  = mk("fwd_b",     0,  0,  3,  7,  0,  7,  3,  0,  0,  1,  1,  0, O_IDLE, O_IDLE, 2'b01, 2'b10);
    vt[10] = mk("fwd_nowrm", 0,  0,  5,  5,  0,  5,  5,  0,  0,  0,  1,  0, O_IDLE, O_IDLE, 2'b01, 2'b01);
    vt[11] = mk("raw_m",     0,  9,  0,  0,  0,  9,  0,  0,  0,  1,  0,  0, O_IDLE, O_LU,   2'b00, 2'b00);
    vt[12] = mk("raw_e_alu", 4,  0,  0,  0,  4,  0,  0,  1,  0,  0,  0,  0, O_IDLE, O_LU,   2'b00, 2'b00);
    vt[13] = mk("raw_w",     6,  0,  0,  0,  0,  0,  6,  0,  0,  0,  1,  0, O_IDLE, O_IDLE, 2'b00, 2'b00);

    // Reset holds every output low even with a hazard on the inputs.
    RESET_N = 1'b0;
    set_load_use();
    PCSrcM = 1'b1; MemAccessM = 1'b1;
    #1;
    check("rst_outputs", 32'(so), 32'(O_IDLE));
    check("rst_stallcnt", 32'(StallCnt), 32'd0);
    check("rst_memerr", 32'(MemErr), 32'd0);
    @(negedge CLOCK);
    RESET_N = 1'b1;
    clear_inputs();

    for (int i = 0; i < 14; i++) begin
      @(negedge CLOCK);
      apply(vt[i]);
      #1;
      check({vt[i].name, "_ctl"}, 32'(so), 32'(FWD ? vt[i].exp_fw : vt[i].exp_nf));
      check({vt[i].name, "_fa"}, 32'(ForwardAE), 32'(FWD ? vt[i].fa : 2'b00));
      check({vt[i].name, "_fb"}, 32'(ForwardBE), 32'(FWD ? vt[i].fb : 2'b00));
    end

    // Load-use: one bubble, then the load moves to M and W.
    do_reset();
    set_load_use();
    #1;
    check("lu_c0_ctl", 32'(so), 32'(O_LU));
    check("lu_c0_cnt", 32'(StallCnt), 32'd0);
    @(negedge CLOCK);
    clear_inputs(); RegWriteM = 1'b1; WriteRegM = 5'd8; RsD = 5'd8;
    #1;
    check("lu_c1_ctl", 32'(so), 32'(FWD ? O_IDLE : O_LU));
    check("lu_c1_cnt", 32'(StallCnt), 32'd1);
    @(negedge CLOCK);
    clear_inputs(); RegWriteW = 1'b1; WriteRegW = 5'd8; RsD = 5'd8;
    #1;
    check("lu_c2_ctl", 32'(so), 32'(O_IDLE));
    check("lu_c2_cnt", 32'(StallCnt), FWD ? 32'd1 : 32'd2);

`ifndef HAZARD_FORWARD_EN
    // Without forwarding, an M-stage producer stalls until it leaves M.
    do_reset();
    clear_inputs(); RegWriteM = 1'b1; WriteRegM = 5'd9; RtD = 5'd9;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("nf_hold_ctl", 32'(so), 32'(O_LU));
      @(negedge CLOCK);
    end
    clear_inputs(); RegWriteW = 1'b1; WriteRegW = 5'd9; RtD = 5'd9;
    #1;
    check("nf_clear_ctl", 32'(so), 32'(O_IDLE));
    check("nf_clear_cnt", 32'(StallCnt), 32'd3);
`endif

    // Memory wait: ready low 3 cycles then high; a branch during the wait is deferred.
    do_reset();
    MemAccessM = 1'b1; MemReadyM = 1'b0;
    #1;
    check("mw_c0_ctl", 32'(so), 32'(O_MW));
    for (int c = 1; c < 4; c++) begin
      @(negedge CLOCK);
      MemReadyM = (c == 3); PCSrcM = 1'b1;
      #1;
      check("mw_wait_ctl", 32'(so), 32'(O_MW));
    end
    @(negedge CLOCK);
    MemAccessM = 1'b0; MemReadyM = 1'b0; PCSrcM = 1'b1;
    #1;
    check("mw_exit_ctl", 32'(so), 32'(O_BR));
    check("mw_exit_cnt", 32'(StallCnt), 32'd4);
    check("mw_exit_err", 32'(MemErr), 32'd0);

    // Timeout with MEM_WAIT_MAX=4: four stalled cycles, then release with MemErr set.
    do_reset();
    MemAccessM = 1'b1; MemReadyM = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c != 0) @(negedge CLOCK);
      #1;
      check("to_wait_ctl", 32'(so), 32'(O_MW));
      check("to_wait_err", 32'(MemErr), 32'd0);
    end
    @(negedge CLOCK);
    MemAccessM = 1'b0;
    #1;
    check("to_rel_ctl", 32'(so), 32'(O_IDLE));
    check("to_rel_err", 32'(MemErr), 32'd1);
    check("to_rel_cnt", 32'(StallCnt), 32'd4);
    repeat (3) @(negedge CLOCK);
    #1;
    check("to_sticky_err", 32'(MemErr), 32'd1);
    @(negedge CLOCK);
    RESET_N = 1'b0;
    #1;
    check("to_rst_err", 32'(MemErr), 32'd0);
    @(negedge CLOCK);
    RESET_N = 1'b1;

    // Reset in the middle of a wait drops stalls at once and returns to RUN.
    do_reset();
    MemAccessM = 1'b1; MemReadyM = 1'b0;
    #1;
    check("rmw_c0_ctl", 32'(so), 32'(O_MW));
    @(negedge CLOCK);
    #1;
    check("rmw_c1_ctl", 32'(so), 32'(O_MW));
    #2;
    RESET_N = 1'b0;
    #1;
    check("rmw_rst_ctl", 32'(so), 32'(O_IDLE));
    check("rmw_rst_cnt", 32'(StallCnt), 32'd0);
    @(negedge CLOCK);
    MemAccessM = 1'b0;
    RESET_N = 1'b1;
    #1;
    check("rmw_run_ctl", 32'(so), 32'(O_IDLE));
    check("rmw_run_cnt", 32'(StallCnt), 32'd0);
    @(negedge CLOCK);
    PCSrcM = 1'b1;
    #1;
    check("rmw_run_br", 32'(so), 32'(O_BR));

    // StallCnt saturates at all-ones (CNT_W=3).
    do_reset();
    set_load_use();
    repeat (9) @(negedge CLOCK);
    clear_inputs();
    #1;
    check("sat_cnt", 32'(StallCnt), 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
